// File: rtl/cache_pkg.sv
// cache_pkg: geometry, address field positions and FSM states for the 2-way cache
package cache_pkg;
  localparam int SETS = 64;
  localparam int INDEX_W = 6;
  localparam int TAG_W = 11;
  localparam int INDEX_LO = 2;
  localparam int INDEX_HI = INDEX_W + 1;
  localparam int TAG_LO = INDEX_W + 2;
  localparam int TAG_HI = 18;
  typedef enum logic [1:0] {IDLE, RD_MISS, WRITE} state_t;
endpackage

// File: rtl/cache_way_array.sv
// cache_way_array: one way of valid/tag/data storage, combinational read, single write port
module cache_way_array
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  output logic               valid,
  output logic [TAG_W-1:0]   tag,
  output logic [31:0]        data,
  input  logic               we,
  input  logic [TAG_W-1:0]   w_tag,
  input  logic [31:0]        w_data
);
  logic [SETS-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [SETS];
  logic [31:0] data_q [SETS];
  assign valid = valid_q[index];
  assign tag = tag_q[index];
  assign data = data_q[index];
  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else if (we) valid_q[index] <= 1'b1;
    if (we) begin
      tag_q[index] <= w_tag;
      data_q[index] <= w_data;
    end
  end
endmodule

// File: rtl/cache_controller.sv
// cache_controller: 2-way set-associative write-through, no-write-allocate cache in front of sram_controller
module cache_controller
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        freeze,
  output logic        sram_r_en,
  output logic        sram_w_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);
  state_t state;
  logic [SETS-1:0] lru;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0] tag, t0, t1;
  logic [31:0] d0, d1, way_wdata;
  logic v0, v1, hit0, hit1, hit, fill, victim, touch, we0, we1;
  assign index = address[INDEX_HI:INDEX_LO];
  assign tag = address[TAG_HI:TAG_LO];
  assign hit0 = v0 && t0 == tag;
  assign hit1 = v1 && t1 == tag;
  assign hit = hit0 | hit1;
  assign fill = state == RD_MISS && sram_ready;
  // victim 1 selects way1: invalid way0 first, then invalid way1, else the LRU way
  assign victim = v0 && (!v1 || lru[index]);
  assign touch = state == IDLE && (mem_r_en || mem_w_en) && hit;
  assign we0 = fill ? !victim : state == IDLE && mem_w_en && hit0;
  assign we1 = fill ? victim : state == IDLE && mem_w_en && hit1;
  assign way_wdata = fill ? sram_rdata : wdata;
  assign sram_r_en = state == RD_MISS;
  assign sram_w_en = state == WRITE;
  assign sram_address = address;
  assign sram_wdata = wdata;
  assign freeze = state == IDLE ? mem_w_en || (mem_r_en && !hit) : !sram_ready;
  assign rdata = fill ? sram_rdata :
                 (state == IDLE && mem_r_en && !mem_w_en && hit) ? (hit0 ? d0 : d1) : '0;
  cache_way_array u_way0 (
    .clk(clk), .rst(rst), .index(index), .valid(v0), .tag(t0), .data(d0),
    .we(we0), .w_tag(tag), .w_data(way_wdata)
  );
  cache_way_array u_way1 (
    .clk(clk), .rst(rst), .index(index), .valid(v1), .tag(t1), .data(d1),
    .we(we1), .w_tag(tag), .w_data(way_wdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lru <= '0;
    end else begin
      state <= state == IDLE ? (mem_w_en ? WRITE : (mem_r_en && !hit) ? RD_MISS : IDLE) :
               sram_ready ? IDLE : state;
      if (touch) lru[index] <= hit0;
      else if (fill) lru[index] <= !victim;
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: random + directed traffic against an MRU-ordered set model, scoreboard-checked
module tb_cache_controller;
  logic clk = 0, rst = 1, mem_r_en = 0, mem_w_en = 0, sram_ready = 0;
  logic freeze, sram_r_en, sram_w_en;
  logic [31:0] address = 0, wdata = 0, sram_rdata = 0, rdata, sram_address, sram_wdata;
  int checks = 0, errors = 0;
  int stall = 0, r_rise = 0, w_rise = 0, sram_lat = 0;
  bit prev_r = 0, prev_w = 0, mon_off = 1, sram_hold = 0;
  typedef struct {bit w; bit hit; logic [31:0] addr; logic [31:0] data;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic [31:0] ref_mem [bit [31:0]];
  logic [31:0] sram_mem [bit [31:0]];
  logic [10:0] ways [64][$];
  logic [10:0] tags [4] = '{11'h001, 11'h041, 11'h081, 11'h002};
  logic [5:0] idxs [3] = '{6'd0, 6'd1, 6'd5};

  always #5 clk = ~clk;

  cache_controller dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .address(address), .wdata(wdata), .rdata(rdata), .freeze(freeze),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en), .sram_address(sram_address),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  function automatic logic [31:0] seed_val(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // Each set is a recency list of tags, most recent first, at most two entries.
  function automatic bit model_access(input int s, input logic [10:0] t, input bit w);
    for (int i = 0; i < ways[s].size(); i++)
      if (ways[s][i] == t) begin
        ways[s].delete(i);
        ways[s].push_front(t);
        return 1'b1;
      end
    if (!w) begin
      ways[s].push_front(t);
      if (ways[s].size() > 2) void'(ways[s].pop_back());
    end
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_op(input bit w, input logic [31:0] a, input logic [31:0] d);
    exp_t x;
    int n;
    mem_w_en = w;
    mem_r_en = !w;
    address = a;
    wdata = d;
    x.w = w;
    x.addr = a;
    x.hit = model_access(int'(a[7:2]), a[18:8], w);
    if (w) ref_mem[a] = d;
    x.data = ref_mem.exists(a) ? ref_mem[a] : seed_val(a);
    sb.push_back(x);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (freeze && n < 40);
    if (freeze) begin
      checks++;
      errors++;
      $display("FAIL timeout addr=%h actual=frozen required=released", a);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    mem_r_en = 0;
    mem_w_en = 0;
    @(posedge clk); #1;
  endtask

  // SRAM responder: random latency, one-cycle ready pulse, garbage data otherwise
  initial forever begin
    @(posedge clk); #1;
    if (sram_ready || rst) begin
      sram_ready = 0;
      sram_rdata = $urandom;
      sram_lat = $urandom_range(0, 3);
    end else if ((sram_r_en || sram_w_en) && !sram_hold) begin
      if (sram_lat == 0) begin
        sram_ready = 1;
        if (sram_w_en) sram_mem[sram_address] = sram_wdata;
        else sram_rdata = sram_mem.exists(sram_address) ? sram_mem[sram_address] : seed_val(sram_address);
        sram_lat = $urandom_range(0, 3);
      end else sram_lat--;
    end
  end

  // Monitor: pops one expectation each time a request completes (freeze low)
  initial forever begin
    @(negedge clk);
    if (!mon_off && !rst) begin
      if (sram_r_en && !prev_r) r_rise++;
      if (sram_w_en && !prev_w) w_rise++;
      prev_r = sram_r_en;
      prev_w = sram_w_en;
      if (mem_r_en || mem_w_en) begin
        if (freeze) stall++;
        else if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow actual=completion required=none addr=%h", address);
        end else begin
          e = sb.pop_front();
          check("stalled", {31'b0, stall != 0}, {31'b0, e.w || !e.hit});
          check("sram_rd_reqs", r_rise, (!e.w && !e.hit) ? 1 : 0);
          check("sram_wr_reqs", w_rise, e.w ? 1 : 0);
          check("sram_address", sram_address, e.addr);
          check("sram_wdata", sram_wdata, wdata);
          if (!e.w) check("rdata", rdata, e.data);
          stall = 0;
          r_rise = 0;
          w_rise = 0;
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_freeze", freeze, 0);
    check("reset_sram_r_en", sram_r_en, 0);
    check("reset_sram_w_en", sram_w_en, 0);
    check("reset_rdata", rdata, 0);
    @(posedge clk); #1;
    mon_off = 0;
    sram_mem[32'h100] = 32'hDEADBEEF;
    ref_mem[32'h100] = 32'hDEADBEEF;
    do_op(0, 32'h100, 0);
    do_op(0, 32'h100, 0);
    do_op(1, 32'h100, 32'h12345678);
    do_op(0, 32'h100, 0);
    do_op(1, 32'h200, 32'hCAFEF00D);
    do_op(0, 32'h200, 0);
    idle();
    mon_off = 1;
    sram_hold = 1;
    mem_r_en = 1;
    address = 32'h300;
    @(negedge clk);
    check("miss_freeze", freeze, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rd_miss_req", sram_r_en, 1);
    check("rd_miss_freeze", freeze, 1);
    @(posedge clk); #1;
    rst = 1;
    mem_r_en = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("abort_sram_r_en", sram_r_en, 0);
    check("abort_freeze", freeze, 0);
    for (int s = 0; s < 64; s++) ways[s].delete();
    sram_hold = 0;
    prev_r = 0;
    prev_w = 0;
    stall = 0;
    r_rise = 0;
    w_rise = 0;
    @(posedge clk); #1;
    mon_off = 0;
    do_op(0, 32'h100, 0);
    do_op(0, 32'h4100, 0);
    do_op(0, 32'h100, 0);
    do_op(0, 32'h8100, 0);
    do_op(0, 32'h100, 0);
    do_op(0, 32'h4100, 0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) idle();
      a = {13'b0, tags[$urandom_range(0, 3)], idxs[$urandom_range(0, 2)], 2'b00};
      do_op($urandom_range(0, 9) < 3, a, $urandom);
    end
    idle();
    idle();
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
